// File: rtl/peri_serial_ctrl.sv
// peri_serial_ctrl: MSB-first serial master with chip select, abort and registered outputs
module peri_serial_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] data_in,
  input  logic [3:0]  len,
  input  logic        P_MISO,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        P_CLOCK,
  output logic        P_DATA,
  output logic        P_CS
);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} state_t;
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [15:0] tx, tx_n, rx_sh, rx_sh_n;
  logic last, act_n;
  assign last = cnt == 8'd0;
  assign act_n = state_n == SETUP || state_n == HIGH || state_n == LOW || state_n == HOLD;
  always_comb begin
    state_n = state;
    cnt_n = last ? 8'd0 : cnt - 8'd1;
    idx_n = idx;
    tx_n = tx;
    rx_sh_n = rx_sh;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = SETUP;
        cnt_n = RELOAD;
        idx_n = len - 4'd1;
        tx_n = data_in;
        rx_sh_n = 16'h0000;
      end
      SETUP: if (last) begin
        state_n = HIGH;
        cnt_n = RELOAD;
      end
      HIGH: begin
        if (cnt == RELOAD) rx_sh_n = {rx_sh[14:0], P_MISO};
        if (last) begin
          state_n = idx == 4'd0 ? HOLD : LOW;
          idx_n = idx == 4'd0 ? idx : idx - 4'd1;
          cnt_n = RELOAD;
        end
      end
      LOW: if (last) begin
        state_n = HIGH;
        cnt_n = RELOAD;
      end
      HOLD: if (last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE && state != DONE) begin
      state_n = IDLE;
      cnt_n = 8'd0;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      idx <= 4'd0;
      tx <= 16'h0000;
      rx_sh <= 16'h0000;
      rx_data <= 16'h0000;
      busy <= 1'b0;
      done <= 1'b0;
      P_CLOCK <= 1'b0;
      P_DATA <= 1'b0;
      P_CS <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      tx <= tx_n;
      rx_sh <= rx_sh_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      P_CLOCK <= state_n == HIGH;
      P_DATA <= act_n & tx_n[idx_n];
      P_CS <= !act_n;
      if (state_n == DONE) rx_data <= rx_sh_n;
    end
endmodule

// File: tb/tb_peri_serial_ctrl.sv
// tb_peri_serial_ctrl: scoreboard bench for peri_serial_ctrl at CLK_DIV=2 and CLK_DIV=1
module tb_peri_serial_ctrl;
  logic clock = 0, reset = 0, start = 0, start1 = 0, abort = 0, miso = 0, loopback = 0, sel = 0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0] len = 4'd0;
  logic busy, done, P_CLOCK, P_DATA, P_CS, miso_w;
  logic busy1, done1, P_CLOCK1, P_DATA1, P_CS1;
  logic [15:0] rx_data, rx_data1;
  logic m_busy, m_done, m_clk, m_data;
  logic [15:0] m_rx;
  int n_vec = 0, n_err = 0;
  typedef struct {logic [15:0] rx; logic [15:0] bits; int bcyc; int edges; int hi;} exp_t;
  exp_t q[$];
  int bcyc = 0, edges = 0, hi = 0;
  logic [15:0] bits = 16'h0000;
  logic pclk_q = 0, pdata_q = 0;

  assign miso_w = loopback ? P_DATA : miso;
  assign m_busy = sel ? busy1 : busy;
  assign m_done = sel ? done1 : done;
  assign m_clk = sel ? P_CLOCK1 : P_CLOCK;
  assign m_data = sel ? P_DATA1 : P_DATA;
  assign m_rx = sel ? rx_data1 : rx_data;

  peri_serial_ctrl #(.CLK_DIV(2)) dut (.clock(clock), .reset(reset), .start(start), .abort(abort),
    .data_in(data_in), .len(len), .P_MISO(miso_w), .busy(busy), .done(done), .rx_data(rx_data),
    .P_CLOCK(P_CLOCK), .P_DATA(P_DATA), .P_CS(P_CS));
  peri_serial_ctrl #(.CLK_DIV(1)) dut1 (.clock(clock), .reset(reset), .start(start1), .abort(abort),
    .data_in(data_in), .len(len), .P_MISO(miso), .busy(busy1), .done(done1), .rx_data(rx_data1),
    .P_CLOCK(P_CLOCK1), .P_DATA(P_DATA1), .P_CS(P_CS1));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      bcyc = 0; edges = 0; hi = 0; bits = 16'h0000;
    end else begin
      if (m_clk && pclk_q) chk("pdata_stable", m_data, pdata_q);
      if (m_clk && !pclk_q) begin
        edges++;
        bits = {bits[14:0], m_data};
      end
      if (m_clk) hi++;
      if (m_busy) bcyc++;
      if (m_done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rx_data", m_rx, e.rx);
          chk("pdata_seq", bits, e.bits);
          chk("busy_cycles", bcyc, e.bcyc);
          chk("pclk_edges", edges, e.edges);
          chk("pclk_high", hi, e.hi);
        end
      end
      if (!m_busy) begin
        bcyc = 0; edges = 0; hi = 0; bits = 16'h0000;
      end
    end
    pclk_q = m_clk;
    pdata_q = m_data;
  end

  task automatic push_exp(input logic [15:0] d, input logic [3:0] l, input int mode);
    exp_t e;
    int n = (l == 4'd0) ? 16 : int'(l);
    int cd = sel ? 1 : 2;
    logic [15:0] mask = 16'((32'd1 << n) - 1);
    e.bits = d & mask;
    e.rx = mode == 2 ? (d & mask) : mode == 1 ? mask : 16'h0000;
    e.bcyc = cd * (2 * n + 1) + 1;
    e.edges = n;
    e.hi = n * cd;
    q.push_back(e);
  endtask

  task automatic wait_pulse();
    for (int i = 0; i < 400 && !m_done; i++) begin
      @(posedge clock); #1;
    end
    if (!m_done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_done();
    wait_pulse();
    @(posedge clock); #1;
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic pulse_start(input logic [15:0] d, input logic [3:0] l, input int mode);
    @(posedge clock); #1;
    data_in = d; len = l; miso = (mode == 1); loopback = (mode == 2);
    if (sel) start1 = 1; else start = 1;
    @(posedge clock); #1;
    start = 0; start1 = 0;
  endtask

  task automatic xfer(input logic [15:0] d, input logic [3:0] l, input int mode);
    push_exp(d, l, mode);
    pulse_start(d, l, mode);
    wait_done();
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] rx);
    chk({tag, "_cs"}, P_CS, 1);
    chk({tag, "_clk"}, P_CLOCK, 0);
    chk({tag, "_data"}, P_DATA, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rx"}, rx_data, rx);
  endtask

  initial begin
    #12;
    chk_idle("reset", 16'h0000);
    chk("reset_cs1", P_CS1, 1);
    chk("reset_rx1", rx_data1, 16'h0000);
    @(negedge clock) reset = 1;
    xfer(16'hA5C3, 4'd0, 2);
    xfer(16'h5A5A, 4'd8, 2);
    xfer(16'h7FFE, 4'd15, 2);
    xfer(16'h000B, 4'd4, 1);
    chk("rx_hold", rx_data, 16'h000F);
    pulse_start(16'hFFFF, 4'd0, 2);
    repeat (4) begin @(posedge clock); #1; end
    abort = 1;
    @(posedge clock); #1;
    abort = 0;
    chk_idle("abort", 16'h000F);
    repeat (80) begin @(posedge clock); #1; end
    chk("abort_rx_hold", rx_data, 16'h000F);
    start = 1; abort = 1;
    @(posedge clock); #1;
    start = 0; abort = 0;
    chk_idle("abort_start", 16'h000F);
    push_exp(16'h0001, 4'd1, 2);
    push_exp(16'h0001, 4'd1, 2);
    @(posedge clock); #1;
    data_in = 16'h0001; len = 4'd1; loopback = 1; start = 1;
    wait_pulse();
    @(posedge clock); #1;
    chk("cont_idle_busy", busy, 0);
    @(posedge clock); #1;
    chk("cont_restart_busy", busy, 1);
    chk("cont_restart_cs", P_CS, 0);
    start = 0;
    wait_done();
    chk("cont_rx", rx_data, 16'h0001);
    push_exp(16'h1234, 4'd0, 2);
    pulse_start(16'h1234, 4'd0, 2);
    for (int i = 0; i < 100 && !P_CLOCK; i++) begin @(posedge clock); #1; end
    chk("pre_reset_high", P_CLOCK, 1);
    #2 reset = 0;
    #1 chk_idle("async_reset", 16'h0000);
    q.delete();
    @(negedge clock); #1 reset = 1;
    xfer(16'hC0DE, 4'd0, 2);
    sel = 1;
    xfer(16'h0001, 4'd1, 0);
    xfer(16'h8001, 4'd0, 1);
    xfer(16'h0006, 4'd3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
